// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluc codes, MIPS opcode/funct values and the issue entry layout.
package alu_pkg;

   typedef logic [3:0] aluc_t;

   localparam aluc_t ALU_ADDU = 4'b0000;
   localparam aluc_t ALU_SUBU = 4'b0001;
   localparam aluc_t ALU_ADD  = 4'b0010;
   localparam aluc_t ALU_SUB  = 4'b0011;
   localparam aluc_t ALU_AND  = 4'b0100;
   localparam aluc_t ALU_OR   = 4'b0101;
   localparam aluc_t ALU_XOR  = 4'b0110;
   localparam aluc_t ALU_NOR  = 4'b0111;
   localparam aluc_t ALU_LUI  = 4'b1000;
   localparam aluc_t ALU_SLTU = 4'b1010;
   localparam aluc_t ALU_SLT  = 4'b1011;
   localparam aluc_t ALU_SRA  = 4'b1100;
   localparam aluc_t ALU_SRL  = 4'b1101;
   localparam aluc_t ALU_SLL  = 4'b1110;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      aluc_t       aluc;
      logic [4:0]  wb_addr;
      logic        wb_en;
      logic        ovf_chk;
      logic        illegal;
   } issue_entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_ONE,
      OCC_TWO
   } occ_state_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake bundle of the ALU issue stage: upstream instruction side and downstream ALU side.
interface alu_issue_stage_if
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   aluc_t             aluc;
   logic [4:0]        wb_addr;
   logic              wb_en;
   logic              ovf_chk;
   logic              illegal;

   modport master (
      output in_valid, instr, rs_data, rt_data, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, aluc, wb_addr, wb_en, ovf_chk, illegal
   );

   modport slave (
      input  in_valid, instr, rs_data, rt_data, out_ready,
      output in_ready, out_valid, alu_a, alu_b, aluc, wb_addr, wb_en, ovf_chk, illegal
   );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational decode of an ALU-class MIPS instruction into an issue entry.
module alu_issue_decode
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output issue_entry_t      entry
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic        legal;
   logic        unused_rs_field;

   assign op              = instr[31:26];
   assign funct           = instr[5:0];
   assign imm_sext        = {{16{instr[15]}}, instr[15:0]};
   assign imm_zext        = {16'b0, instr[15:0]};
   assign unused_rs_field = ^instr[25:21];

   // Unrecognised encodings collapse to an all-zero entry flagged illegal.
   always_comb begin
      entry = '0;
      legal = 1'b1;
      if (op == OP_RTYPE) begin
         entry.a       = rs_data;
         entry.b       = rt_data;
         entry.wb_addr = instr[15:11];
         case (funct)
            FN_ADD:  begin entry.aluc = ALU_ADD; entry.ovf_chk = 1'b1; end
            FN_ADDU: entry.aluc = ALU_ADDU;
            FN_SUB:  begin entry.aluc = ALU_SUB; entry.ovf_chk = 1'b1; end
            FN_SUBU: entry.aluc = ALU_SUBU;
            FN_AND:  entry.aluc = ALU_AND;
            FN_OR:   entry.aluc = ALU_OR;
            FN_XOR:  entry.aluc = ALU_XOR;
            FN_NOR:  entry.aluc = ALU_NOR;
            FN_SLT:  entry.aluc = ALU_SLT;
            FN_SLTU: entry.aluc = ALU_SLTU;
            FN_SLL:  begin entry.aluc = ALU_SLL; entry.a = {27'b0, instr[10:6]}; end
            FN_SRL:  begin entry.aluc = ALU_SRL; entry.a = {27'b0, instr[10:6]}; end
            FN_SRA:  begin entry.aluc = ALU_SRA; entry.a = {27'b0, instr[10:6]}; end
            FN_SLLV: begin entry.aluc = ALU_SLL; entry.a = {27'b0, rs_data[4:0]}; end
            FN_SRLV: begin entry.aluc = ALU_SRL; entry.a = {27'b0, rs_data[4:0]}; end
            FN_SRAV: begin entry.aluc = ALU_SRA; entry.a = {27'b0, rs_data[4:0]}; end
            default: legal = 1'b0;
         endcase
      end else begin
         entry.a       = rs_data;
         entry.b       = imm_sext;
         entry.wb_addr = instr[20:16];
         case (op)
            OP_ADDI:  begin entry.aluc = ALU_ADD; entry.ovf_chk = 1'b1; end
            OP_ADDIU: entry.aluc = ALU_ADDU;
            OP_SLTI:  entry.aluc = ALU_SLT;
            OP_SLTIU: entry.aluc = ALU_SLTU;
            OP_ANDI:  begin entry.aluc = ALU_AND; entry.b = imm_zext; end
            OP_ORI:   begin entry.aluc = ALU_OR;  entry.b = imm_zext; end
            OP_XORI:  begin entry.aluc = ALU_XOR; entry.b = imm_zext; end
            OP_LUI:   begin entry.aluc = ALU_LUI; entry.a = '0; entry.b = imm_zext; end
            default:  legal = 1'b0;
         endcase
      end

      if (!legal) begin
         entry         = '0;
         entry.illegal = 1'b1;
      end else begin
         entry.wb_en = (entry.wb_addr != 5'd0);
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode followed by a 2-entry skid buffer.
// Optional ALU_ISSUE_STATS_EN adds saturating issue_cnt/stall_cnt outputs.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   alu_issue_stage_if.slave  bus
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [STAT_W-1:0] issue_cnt,
   output logic [STAT_W-1:0] stall_cnt
`endif
);

   occ_state_t   state_q, state_d;
   issue_entry_t dec_entry, main_q, skid_q;
   logic         accept, present;
   logic         load_main_new, load_main_skid, load_skid;

   alu_issue_decode #(.DATA_W(DATA_W)) u_decode (
      .instr   (bus.instr),
      .rs_data (bus.rs_data),
      .rt_data (bus.rt_data),
      .entry   (dec_entry)
   );

   // Ready depends only on occupancy, so out_ready never reaches in_ready combinationally.
   assign bus.in_ready  = (state_q != OCC_TWO);
   assign bus.out_valid = (state_q != OCC_EMPTY);
   assign accept        = bus.in_valid & bus.in_ready;
   assign present       = bus.out_valid & bus.out_ready;

   assign bus.alu_a   = main_q.a;
   assign bus.alu_b   = main_q.b;
   assign bus.aluc    = main_q.aluc;
   assign bus.wb_addr = main_q.wb_addr;
   assign bus.wb_en   = main_q.wb_en;
   assign bus.ovf_chk = main_q.ovf_chk;
   assign bus.illegal = main_q.illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= OCC_EMPTY;
      else        state_q <= state_d;
   end

   // Flush overrides every transfer; skid only fills when main is stalled.
   always_comb begin
      state_d        = state_q;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = OCC_EMPTY;
      end else begin
         case (state_q)
            OCC_EMPTY: if (accept) begin state_d = OCC_ONE; load_main_new = 1'b1; end
            OCC_ONE: begin
               if (present && accept)  load_main_new = 1'b1;
               else if (present)       state_d = OCC_EMPTY;
               else if (accept)        begin state_d = OCC_TWO; load_skid = 1'b1; end
            end
            OCC_TWO:   if (present) begin state_d = OCC_ONE; load_main_skid = 1'b1; end
            default:   state_d = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_new)       main_q <= dec_entry;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= dec_entry;
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   // Counters survive flush and stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (present && !(&issue_cnt))                    issue_cnt <= issue_cnt + 1'b1;
         if (bus.out_valid && !bus.out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   logic unused_stat_w;
   assign unused_stat_w = ^STAT_W;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode cases, skid/flush scenarios, randomized scoreboard.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  aluc;
      logic [4:0]  wb_addr;
      logic        wb_en;
      logic        ovf;
      logic        ill;
   } exp_t;

   logic clk;
   logic rst_n;
   logic flush;
   int   checks;
   int   errors;

   alu_issue_stage_if #(.DATA_W(32)) bus ();

`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] issue_cnt;
   logic [31:0] stall_cnt;
`endif

   alu_issue_stage #(.DATA_W(32), .STAT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
`ifdef ALU_ISSUE_STATS_EN
      ,
      .issue_cnt (issue_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
      rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                               input logic [4:0] w, input logic en, input logic ovf, input logic ill);
      mk = '{a: a, b: b, aluc: c, wb_addr: w, wb_en: en, ovf: ovf, ill: ill};
   endfunction

   function automatic exp_t get_obs();
      get_obs = '{a: bus.alu_a, b: bus.alu_b, aluc: bus.aluc, wb_addr: bus.wb_addr,
                  wb_en: bus.wb_en, ovf: bus.ovf_chk, ill: bus.illegal};
   endfunction

   // Reference decode written from the instruction-set tables
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
      exp_t        e;
      bit          ok;
      logic [5:0]  op, fn;
      logic [31:0] simm, zimm;
      op   = ins[31:26];
      fn   = ins[5:0];
      simm = int'($signed(ins[15:0]));
      zimm = 32'(ins[15:0]);
      e    = '0;
      ok   = 1'b1;
      if (op == 6'h00) begin
         e.a = rsd; e.b = rtd; e.wb_addr = ins[15:11];
         case (fn)
            6'h20: begin e.aluc = 4'b0010; e.ovf = 1'b1; end
            6'h21: e.aluc = 4'b0000;
            6'h22: begin e.aluc = 4'b0011; e.ovf = 1'b1; end
            6'h23: e.aluc = 4'b0001;
            6'h24: e.aluc = 4'b0100;
            6'h25: e.aluc = 4'b0101;
            6'h26: e.aluc = 4'b0110;
            6'h27: e.aluc = 4'b0111;
            6'h2A: e.aluc = 4'b1011;
            6'h2B: e.aluc = 4'b1010;
            6'h00: begin e.aluc = 4'b1110; e.a = 32'(ins[10:6]); end
            6'h02: begin e.aluc = 4'b1101; e.a = 32'(ins[10:6]); end
            6'h03: begin e.aluc = 4'b1100; e.a = 32'(ins[10:6]); end
            6'h04: begin e.aluc = 4'b1110; e.a = rsd % 32; end
            6'h06: begin e.aluc = 4'b1101; e.a = rsd % 32; end
            6'h07: begin e.aluc = 4'b1100; e.a = rsd % 32; end
            default: ok = 1'b0;
         endcase
      end else begin
         e.a = rsd; e.wb_addr = ins[20:16];
         case (op)
            6'h08: begin e.b = simm; e.aluc = 4'b0010; e.ovf = 1'b1; end
            6'h09: begin e.b = simm; e.aluc = 4'b0000; end
            6'h0A: begin e.b = simm; e.aluc = 4'b1011; end
            6'h0B: begin e.b = simm; e.aluc = 4'b1010; end
            6'h0C: begin e.b = zimm; e.aluc = 4'b0100; end
            6'h0D: begin e.b = zimm; e.aluc = 4'b0101; end
            6'h0E: begin e.b = zimm; e.aluc = 4'b0110; end
            6'h0F: begin e.a = 32'd0; e.b = zimm; e.aluc = 4'b1000; end
            default: ok = 1'b0;
         endcase
      end
      if (!ok) begin
         e     = '0;
         e.ill = 1'b1;
      end else begin
         e.wb_en = (e.wb_addr != 5'd0);
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      int          k;
      logic [5:0]  rfn [16];
      logic [5:0]  iop [8];
      rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      iop = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      k = $urandom_range(0, 9);
      if (k < 5)
         rand_instr = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                            $urandom_range(0, 31), int'(rfn[$urandom_range(0, 15)]));
      else if (k < 9)
         rand_instr = itype(int'(iop[$urandom_range(0, 7)]), $urandom_range(0, 31),
                            $urandom_range(0, 31), $urandom_range(0, 65535));
      else
         rand_instr = $urandom;
   endfunction

   task automatic drive_idle();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      flush         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t obs;
      obs = get_obs();
      checks++;
      if (obs !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", obs); end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_hs: got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL post_reset_hs: got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_decode_directed();
      logic [31:0] ins [9];
      logic [31:0] rsv [9];
      logic [31:0] rtv [9];
      exp_t        want [9];
      exp_t        obs;
      ins[0] = rtype(1, 2, 3, 0, 'h21);  rsv[0] = 5;            rtv[0] = 7;
      want[0] = mk(5, 7, 4'b0000, 3, 1, 0, 0);
      ins[1] = rtype(0, 5, 4, 8, 'h03);  rsv[1] = 0;            rtv[1] = 32'h8000_0000;
      want[1] = mk(8, 32'h8000_0000, 4'b1100, 4, 1, 0, 0);
      ins[2] = rtype(6, 5, 4, 0, 'h07);  rsv[2] = 32'hFFFF_FF24; rtv[2] = 32'h8000_0000;
      want[2] = mk(4, 32'h8000_0000, 4'b1100, 4, 1, 0, 0);
      ins[3] = itype('h08, 9, 8, 'hFFFF); rsv[3] = 10;           rtv[3] = 32'h55;
      want[3] = mk(10, 32'hFFFF_FFFF, 4'b0010, 8, 1, 1, 0);
      ins[4] = itype('h0C, 9, 8, 'hFFFF); rsv[4] = 32'h1234_5678; rtv[4] = 0;
      want[4] = mk(32'h1234_5678, 32'h0000_FFFF, 4'b0100, 8, 1, 0, 0);
      ins[5] = itype('h0F, 0, 7, 'h1234); rsv[5] = 32'hDEAD;     rtv[5] = 1;
      want[5] = mk(0, 32'h0000_1234, 4'b1000, 7, 1, 0, 0);
      ins[6] = itype('h23, 1, 2, 4);      rsv[6] = 3;            rtv[6] = 9;
      want[6] = mk(0, 0, 4'b0000, 0, 0, 0, 1);
      ins[7] = rtype(1, 2, 0, 0, 'h21);  rsv[7] = 5;            rtv[7] = 7;
      want[7] = mk(5, 7, 4'b0000, 0, 0, 0, 0);
      ins[8] = rtype(3, 4, 2, 0, 'h22);  rsv[8] = 100;          rtv[8] = 1;
      want[8] = mk(100, 1, 4'b0011, 2, 1, 1, 0);
      for (int i = 0; i < 9; i++) begin
         bus.instr = ins[i]; bus.rs_data = rsv[i]; bus.rt_data = rtv[i];
         bus.in_valid = 1'b1; bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         obs = get_obs();
         checks++;
         if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL directed_valid[%0d]: got %b want 1", i, bus.out_valid); end
         checks++;
         if (obs !== want[i]) begin errors++; $display("[TB] FAIL directed_entry[%0d]: got %h want %h", i, obs, want[i]); end
      end
      drive_idle();
   endtask

   task automatic test_back_to_back();
      exp_t e0, e1, obs;
      e0 = mk(11, 22, 4'b0000, 1, 1, 0, 0);
      e1 = mk(32'h100, 32'h00F0, 4'b0101, 5, 1, 0, 0);
      bus.out_ready = 1'b0;
      bus.instr = rtype(2, 3, 1, 0, 'h21); bus.rs_data = 11; bus.rt_data = 22; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready1: got %b want 1", bus.in_ready); end
      bus.instr = itype('h0D, 6, 5, 'h00F0); bus.rs_data = 32'h100; bus.rt_data = 0;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready2: got %b want 0", bus.in_ready); end
      bus.instr = rtype(1, 1, 9, 0, 'h26); bus.rs_data = 1; bus.rt_data = 2;
      @(posedge clk); #1;
      obs = get_obs();
      checks++;
      if (bus.in_ready !== 1'b0 || obs !== e0) begin
         errors++; $display("[TB] FAIL b2b_hold: got ready=%b entry=%h want ready=0 entry=%h", bus.in_ready, obs, e0);
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      obs = get_obs();
      checks++;
      if (bus.out_valid !== 1'b1 || obs !== e1) begin
         errors++; $display("[TB] FAIL b2b_second: got valid=%b entry=%h want valid=1 entry=%h", bus.out_valid, obs, e1);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got valid=%b want 0", bus.out_valid); end
      drive_idle();
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.instr = rtype(1, 2, 3, 0, 'h24); bus.rs_data = 1; bus.rt_data = 2;
      @(posedge clk); #1;
      bus.instr = rtype(1, 2, 4, 0, 'h25);
      @(posedge clk); #1;
      bus.instr = itype('h0E, 1, 6, 'h00AA);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL flush_two: got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
      end
      // one entry held, accept offered alongside flush
      bus.in_valid = 1'b1; bus.instr = rtype(1, 2, 3, 0, 'h21);
      @(posedge clk); #1;
      bus.instr = itype('h0D, 1, 7, 'h0001); bus.out_ready = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_accept: got valid=%b want 0", bus.out_valid); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_leak[%0d]: got valid=%b want 0", i, bus.out_valid); end
      end
      drive_idle();
   endtask

   task automatic test_random();
      exp_t        q[$];
      exp_t        obs, e;
      logic [31:0] ins, rsd, rtd;
      bit          acc, pres, fl;
      logic        want_valid, want_ready;
      for (int cyc = 0; cyc < 500; cyc++) begin
         want_valid = (q.size() > 0) ? 1'b1 : 1'b0;
         want_ready = (q.size() < 2) ? 1'b1 : 1'b0;
         checks++;
         if (bus.out_valid !== want_valid) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %b want %b", cyc, bus.out_valid, want_valid); end
         checks++;
         if (bus.in_ready !== want_ready) begin errors++; $display("[TB] FAIL rand_ready@%0d: got %b want %b", cyc, bus.in_ready, want_ready); end
         if (q.size() > 0) begin
            obs = get_obs();
            checks++;
            if (obs !== q[0]) begin errors++; $display("[TB] FAIL rand_entry@%0d: got %h want %h", cyc, obs, q[0]); end
         end
         ins = rand_instr(); rsd = $urandom; rtd = $urandom;
         bus.instr = ins; bus.rs_data = rsd; bus.rt_data = rtd;
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         fl            = ($urandom_range(0, 24) == 0);
         flush         = fl;
         acc  = bus.in_valid && (q.size() < 2);
         pres = (q.size() > 0) && bus.out_ready;
         e    = ref_decode(ins, rsd, rtd);
         @(posedge clk); #1;
         if (fl) q.delete();
         else begin
            if (pres) void'(q.pop_front());
            if (acc)  q.push_back(e);
         end
      end
      drive_idle();
   endtask

   task automatic test_reset_mid();
      exp_t obs;
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.instr = itype('h09, 1, 2, 'h7FFF); bus.rs_data = 32'hCAFE; bus.rt_data = 0;
      @(posedge clk); #1;
      bus.instr = rtype(1, 2, 3, 0, 'h27);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      obs = get_obs();
      checks++;
      if (obs !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_mid: got valid=%b ready=%b entry=%h want valid=0 ready=1 entry=0", bus.out_valid, bus.in_ready, obs);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_after: got valid=%b want 0", bus.out_valid); end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.instr = '0; bus.rs_data = '0; bus.rt_data = '0;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] starting");
      test_reset();
      test_decode_directed();
      test_back_to_back();
      test_flush();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
